// File: rtl/alu_cmd_frontend.sv
// -----------------------------------------------------------------------------
// alu_cmd_frontend
//   Operand/opcode loader and issue controller sitting between the lab board
//   push-buttons and an ALU. Three load strobes latch the shared switch bus into
//   operand A, operand B and the opcode. A fourth strobe, go, issues the command
//   when automatic issue is disabled. All strobes are asynchronous. Each one is
//   synchronised, debounced and turned into a single-cycle pulse, and none of
//   them is used as a clock. Commands go to the ALU over a valid/ready request,
//   and completion is signalled by a one-cycle done pulse. The result and flags
//   are then held for the display path.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   data              shared switch bus (opcode is its top OP_W bits)
//   ld_a, ld_b, ld_op asynchronous load strobes
//   go                asynchronous issue strobe (unused when AUTO_ISSUE=1)
//   alu_a, alu_b      operand registers presented to the ALU
//   alu_op            opcode register presented to the ALU
//   alu_valid         request valid (registered, high in ISSUE)
//   alu_ready         ALU accepts the request
//   alu_done          one-cycle completion pulse, qualifies alu_res/alu_flags
//   result, flags     held result/flags of the last completed command
//   res_valid         result/flags belong to the latest issued command
//   loaded            sticky {op,b,a} loaded bits
//   busy              controller is in ISSUE or WAIT
//   err               sticky {timeout, dropped_load}
// -----------------------------------------------------------------------------
module alu_cmd_frontend #(
    parameter int WIDTH      = 32,
    parameter int OP_W       = 4,
    parameter int DEBOUNCE   = 16,
    parameter int AUTO_ISSUE = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_op,
    input  logic             go,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_valid,
    input  logic             alu_ready,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [3:0]       alu_flags,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             res_valid,
    output logic [2:0]       loaded,
    output logic             busy,
    output logic [1:0]       err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // WAIT counter must hold the value TIMEOUT; keep at least one bit when
    // the timeout is disabled so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Debounce counter runs 0..DEBOUNCE-1.
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    // Strobe bit order used throughout: {go, ld_op, ld_b, ld_a}.
    logic [3:0] strb_s;
    logic [3:0] sync1_r;
    logic [3:0] sync2_r;
    logic [3:0] filt_r;
    logic [3:0] filt_d_r;
    logic [3:0] pulse_r;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_inc_s;

    logic       can_load_s;
    logic [2:0] accept_s;
    logic [2:0] loaded_nx_s;
    logic       drop_s;
    logic       trigger_s;
    logic       issue_s;
    logic       timeout_hit_s;
    logic       capture_s;
    logic       tmo_s;

    assign strb_s = {go, ld_op, ld_b, ld_a};

    // Two-flop synchroniser for the four asynchronous strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= strb_s;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_nofilt
            // Filter disabled: the synchronised level is taken directly.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt_r <= 4'b0000;
                end else begin
                    filt_r <= sync2_r;
                end
            end
        end else begin : g_filt
            logic [DB_W-1:0] db_cnt_r [4];

            // Filtered level flips only after DEBOUNCE consecutive disagreeing samples.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    filt_r <= 4'b0000;
                    for (int i = 0; i < 4; i++) begin
                        db_cnt_r[i] <= {DB_W{1'b0}};
                    end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (sync2_r[i] != filt_r[i]) begin
                            if (db_cnt_r[i] == DB_W'(DEBOUNCE - 1)) begin
                                filt_r[i]   <= sync2_r[i];
                                db_cnt_r[i] <= {DB_W{1'b0}};
                            end else begin
                                db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1'b1);
                            end
                        end else begin
                            db_cnt_r[i] <= {DB_W{1'b0}};
                        end
                    end
                end
            end
        end
    endgenerate

    // Rising edge of the filtered level becomes a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d_r <= 4'b0000;
            pulse_r  <= 4'b0000;
        end else begin
            filt_d_r <= filt_r;
            pulse_r  <= filt_r & ~filt_d_r;
        end
    end

    // Load acceptance, issue trigger and WAIT timeout decode.
    always_comb begin
        can_load_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
        accept_s    = 3'b000;
        drop_s      = 1'b0;
        if (can_load_s) begin
            accept_s = pulse_r[2:0];
        end else begin
            drop_s = |pulse_r[2:0];
        end
        loaded_nx_s = loaded | accept_s;

        if (AUTO_ISSUE != 0) begin
            trigger_s = |accept_s;
        end else begin
            trigger_s = pulse_r[3];
        end
        issue_s = can_load_s && (loaded_nx_s == 3'b111) && trigger_s;

        if (wait_cnt_r == CNT_MAX) begin
            wait_inc_s = wait_cnt_r;
        end else begin
            wait_inc_s = wait_cnt_r + CNT_ONE;
        end

        // The cycle being counted now is WAIT cycle number wait_cnt_r+1.
        if (TIMEOUT != 0) begin
            timeout_hit_s = (int'(wait_cnt_r) + 32'sd1) >= TIMEOUT;
        end else begin
            timeout_hit_s = 1'b0;
        end

        capture_s = (state_r == ST_WAIT) && alu_done;
        tmo_s     = (state_r == ST_WAIT) && !alu_done && timeout_hit_s;
    end

    // Next-state logic for IDLE/ISSUE/WAIT/DONE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (issue_s) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_ISSUE: begin
                if (alu_valid && alu_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (capture_s || tmo_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, registered request/status outputs and the command/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            alu_valid  <= 1'b0;
            busy       <= 1'b0;
            alu_a      <= {WIDTH{1'b0}};
            alu_b      <= {WIDTH{1'b0}};
            alu_op     <= {OP_W{1'b0}};
            loaded     <= 3'b000;
            err        <= 2'b00;
            result     <= {WIDTH{1'b0}};
            flags      <= 4'b0000;
            res_valid  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            // Valid and busy are decoded from the next state so they line up
            // exactly with the state register.
            alu_valid <= (state_nx_s == ST_ISSUE);
            busy      <= (state_nx_s == ST_ISSUE) || (state_nx_s == ST_WAIT);

            if (accept_s[0]) begin
                alu_a <= data;
            end
            if (accept_s[1]) begin
                alu_b <= data;
            end
            if (accept_s[2]) begin
                alu_op <= data[WIDTH-1 -: OP_W];
            end
            loaded <= loaded_nx_s;
            err    <= err | {tmo_s, drop_s};

            if (capture_s) begin
                result <= alu_res;
                flags  <= alu_flags;
            end

            // A fresh load or a new issue makes the held result stale.
            if (capture_s) begin
                res_valid <= 1'b1;
            end else if ((|accept_s) || issue_s) begin
                res_valid <= 1'b0;
            end

            // Held at zero through ISSUE so it starts from zero on entry to WAIT.
            if (state_r == ST_ISSUE) begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_inc_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Testbench for alu_cmd_frontend: one automatic-issue instance (DEBOUNCE=16,
// TIMEOUT=8) driven through a scoreboard, plus one go-issue instance
// (DEBOUNCE=0, no timeout).
module tb_alu_cmd_frontend;
    localparam int DB      = 16;
    localparam int M_NORMAL = 0;
    localparam int M_NODONE = 1;
    localparam int M_HOLD   = 2;

    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [3:0] op; } hs_t;
    typedef struct packed { logic [31:0] res; logic [3:0] fl; } rs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] data;
    logic        ld_a, ld_b, ld_op, go;
    logic [31:0] alu_a, alu_b, alu_res, result;
    logic [3:0]  alu_op, alu_flags, flags;
    logic        alu_valid, alu_ready, alu_done, res_valid, busy;
    logic [2:0]  loaded;
    logic [1:0]  err;

    logic [31:0] d1_data;
    logic        d1_ld_a, d1_ld_b, d1_ld_op, d1_go;
    logic [31:0] d1_alu_a, d1_alu_b, d1_alu_res, d1_result;
    logic [3:0]  d1_alu_op, d1_alu_flags, d1_flags;
    logic        d1_alu_valid, d1_alu_ready, d1_alu_done, d1_res_valid, d1_busy;
    logic [2:0]  d1_loaded;
    logic [1:0]  d1_err;

    alu_cmd_frontend #(.WIDTH(32), .OP_W(4), .DEBOUNCE(DB), .AUTO_ISSUE(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .ld_a(ld_a), .ld_b(ld_b), .ld_op(ld_op), .go(go),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_done(alu_done), .alu_res(alu_res), .alu_flags(alu_flags), .result(result), .flags(flags),
        .res_valid(res_valid), .loaded(loaded), .busy(busy), .err(err));

    alu_cmd_frontend #(.WIDTH(32), .OP_W(4), .DEBOUNCE(0), .AUTO_ISSUE(0), .TIMEOUT(0)) dut_go (
        .clk(clk), .rst_n(rst_n), .data(d1_data), .ld_a(d1_ld_a), .ld_b(d1_ld_b), .ld_op(d1_ld_op),
        .go(d1_go), .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op), .alu_valid(d1_alu_valid),
        .alu_ready(d1_alu_ready), .alu_done(d1_alu_done), .alu_res(d1_alu_res), .alu_flags(d1_alu_flags),
        .result(d1_result), .flags(d1_flags), .res_valid(d1_res_valid), .loaded(d1_loaded),
        .busy(d1_busy), .err(d1_err));

    int total = 0;
    int bad   = 0;

    // Reference ALU and flag rules used by both the environment and the model.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return ~(a + b);
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] r);
        return {(r == 32'd0), r[31], ^r, r[0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues and the behavioural model of the auto-issue instance.
    hs_t hs_q[$];
    rs_t res_q[$];
    logic [31:0] m_a, m_b, m_result;
    logic [3:0]  m_op, m_flags;
    logic [2:0]  m_loaded;
    logic [1:0]  m_err;
    logic        m_res_valid;

    int rsp_mode = M_NORMAL;
    int rdy_dly  = 0;
    int done_dly = 0;
    int wait_meas = 0;

    task automatic model_reset();
        m_a = 32'd0; m_b = 32'd0; m_result = 32'd0; m_op = 4'd0; m_flags = 4'd0;
        m_loaded = 3'b000; m_err = 2'b00; m_res_valid = 1'b0;
        hs_q.delete();
        res_q.delete();
    endtask

    // ALU environment for the auto-issue instance.
    initial begin : responder
        int st, vcnt, dcnt;
        st = 0; vcnt = 0; dcnt = 0;
        alu_ready = 1'b0; alu_done = 1'b0; alu_res = 32'd0; alu_flags = 4'd0;
        forever begin
            @(negedge clk);
            alu_ready = 1'b0;
            alu_done  = 1'b0;
            if (!rst_n) begin
                st = 0; vcnt = 0; dcnt = 0;
            end else if (st == 0) begin
                if (alu_valid && rsp_mode != M_HOLD) begin
                    if (vcnt >= rdy_dly) begin
                        alu_ready = 1'b1; st = 1; vcnt = 0; dcnt = 0;
                    end else begin
                        vcnt++;
                    end
                end else begin
                    vcnt = 0;
                end
            end else if (rsp_mode == M_NODONE) begin
                st = 0;
            end else if (dcnt >= done_dly) begin
                alu_done  = 1'b1;
                alu_res   = ref_alu(alu_a, alu_b, alu_op);
                alu_flags = ref_flags(alu_res);
                st = 0;
            end else begin
                dcnt++;
            end
        end
    end

    // Monitor: pops expected handshakes and results as the DUT presents them.
    initial begin : monitor
        hs_t e;
        rs_t r;
        logic rv_prev;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (alu_valid && alu_ready) begin
                wait_meas = 0;
                if (hs_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL hs_unexpected: got handshake a=%0h b=%0h op=%0h, expected none", alu_a, alu_b, alu_op);
                end else begin
                    e = hs_q.pop_front();
                    chk("hs_a", alu_a, e.a);
                    chk("hs_b", alu_b, e.b);
                    chk("hs_op", alu_op, e.op);
                end
            end else if (busy && !alu_valid) begin
                wait_meas++;
            end
            if (res_valid && !rv_prev) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL res_unexpected: got result %0h, expected no completion", result);
                end else begin
                    r = res_q.pop_front();
                    chk("res_value", result, r.res);
                    chk("res_flags", flags, r.fl);
                end
            end
            rv_prev = res_valid;
        end
    end

    // Hold one strobe for 20 cycles then release, updating the model.
    task automatic press(input int which, input logic [31:0] val);
        data = val;
        case (which)
            0: m_a = val;
            1: m_b = val;
            default: m_op = val[31:28];
        endcase
        m_loaded[which] = 1'b1;
        m_res_valid = 1'b0;
        if (m_loaded == 3'b111) begin
            hs_q.push_back({m_a, m_b, m_op});
            if (rsp_mode == M_NORMAL) begin
                m_result = ref_alu(m_a, m_b, m_op);
                m_flags  = ref_flags(m_result);
                m_res_valid = 1'b1;
                res_q.push_back({m_result, m_flags});
            end
        end
        case (which)
            0: ld_a = 1'b1;
            1: ld_b = 1'b1;
            default: ld_op = 1'b1;
        endcase
        repeat (20) @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0; ld_op = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        int n;
        n = 0;
        #1;
        while (busy && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_alu_a"}, alu_a, m_a);
        chk({tag, "_alu_b"}, alu_b, m_b);
        chk({tag, "_alu_op"}, alu_op, m_op);
        chk({tag, "_loaded"}, loaded, m_loaded);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_res_valid"}, res_valid, m_res_valid);
        chk({tag, "_result"}, result, m_result);
        chk({tag, "_flags"}, flags, m_flags);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_alu_valid"}, alu_valid, 1'b0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_op"}, alu_op, 4'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_flags"}, flags, 4'd0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_loaded"}, loaded, 3'b000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, 2'b00);
    endtask

    // Go-issue instance: always ready, done one cycle after the handshake.
    int d1_hs = 0;
    assign d1_alu_ready = 1'b1;
    assign d1_alu_res   = ref_alu(d1_alu_a, d1_alu_b, d1_alu_op);
    assign d1_alu_flags = ref_flags(d1_alu_res);

    initial begin : d1_env
        logic pend;
        pend = 1'b0;
        d1_alu_done = 1'b0;
        forever begin
            @(negedge clk);
            d1_alu_done = pend;
            pend = 1'b0;
            #1;
            if (d1_alu_valid) begin
                d1_hs++;
                pend = 1'b1;
            end
        end
    end

    task automatic press1(input int which, input logic [31:0] val);
        d1_data = val;
        case (which)
            0: d1_ld_a = 1'b1;
            1: d1_ld_b = 1'b1;
            2: d1_ld_op = 1'b1;
            default: d1_go = 1'b1;
        endcase
        repeat (4) @(negedge clk);
        d1_ld_a = 1'b0; d1_ld_b = 1'b0; d1_ld_op = 1'b0; d1_go = 1'b0;
        repeat (8) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] ta, d1a, d1b, d1r;
        int n;
        rst_n = 1'b0;
        data = 32'd0; ld_a = 1'b0; ld_b = 1'b0; ld_op = 1'b0; go = 1'b0;
        d1_data = 32'd0; d1_ld_a = 1'b0; d1_ld_b = 1'b0; d1_ld_op = 1'b0; d1_go = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bouncing strobe never settles long enough to load.
        data = 32'hDEAD_BEEF;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) ld_a = ~ld_a;
            @(negedge clk);
        end
        ld_a = 1'b0;
        repeat (24) @(negedge clk);
        check_state("bounce");

        press(0, 32'h1234_5678);
        check_state("load_a");

        // Directed command: 5 + 7, ready on the third valid cycle.
        rdy_dly = 2; done_dly = 0; rsp_mode = M_NORMAL;
        press(0, 32'd5);
        press(1, 32'd7);
        press(2, 32'h0000_0000);
        check_state("directed");
        chk("directed_result12", result, 32'd12);

        // Randomised reloads; every accepted load reissues.
        for (int i = 0; i < 10; i++) begin
            rdy_dly  = $urandom_range(0, 3);
            done_dly = $urandom_range(0, 5);
            press($urandom_range(0, 2), $urandom);
            check_state("random");
        end

        // Load B arriving during WAIT is dropped; ALU never completes.
        rsp_mode = M_NODONE; rdy_dly = 2;
        ta = m_b ^ 32'h5A5A_0001;
        data = ta;
        m_a = ta;
        hs_q.push_back({m_a, m_b, m_op});
        m_err = 2'b11;
        m_res_valid = 1'b0;
        ld_a = 1'b1;
        repeat (6) @(negedge clk);
        ld_b = 1'b1;
        repeat (14) @(negedge clk);
        ld_a = 1'b0;
        repeat (6) @(negedge clk);
        ld_b = 1'b0;
        repeat (24) @(negedge clk);
        check_state("timeout");
        chk("timeout_wait_cycles", wait_meas, 8);
        chk("hs_queue_drained", hs_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);

        // Asynchronous reset while a request is pending in ISSUE.
        rsp_mode = M_HOLD;
        data = 32'hCAFE_0001;
        ld_a = 1'b1;
        n = 0;
        @(negedge clk);
        #1;
        while (!alu_valid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("issue_reached", alu_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_async", alu_valid, 1'b0);
        ld_a = 1'b0;
        model_reset();
        check_zero("in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_mode = M_NORMAL;
        repeat (4) @(negedge clk);
        #1;
        check_zero("after_reset");

        // Go-issue instance: go before opcode is loaded is ignored.
        d1a = $urandom; d1b = $urandom;
        press1(0, d1a);
        press1(1, d1b);
        chk("go_loaded_ab", d1_loaded, 3'b011);
        press1(3, 32'd0);
        chk("go_ignored_hs", d1_hs, 0);
        chk("go_ignored_busy", d1_busy, 1'b0);
        press1(2, 32'h1000_0000);
        chk("go_noauto_hs", d1_hs, 0);
        chk("go_loaded_all", d1_loaded, 3'b111);
        press1(3, 32'd0);
        d1r = d1a - d1b;
        chk("go_one_hs", d1_hs, 1);
        chk("go_result", d1_result, d1r);
        chk("go_flags", d1_flags, ref_flags(d1r));
        chk("go_res_valid", d1_res_valid, 1'b1);
        chk("go_err", d1_err, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
